// File: rtl/cba_seq_adder.sv
// rtl/cba_seq_adder.sv - multi-cycle carry-bypass adder, one BLOCK-bit group per clock
module cba_seq_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4,
    localparam int NBLK = WIDTH / BLOCK,
    localparam int CW   = $clog2(NBLK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [CW-1:0]    bypass_cnt
);

    localparam int IW = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic             carry_q, carry_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic [WIDTH-1:0] s_q, s_n;
    logic             cout_q, cout_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             done_q, done_n;

    logic [BLOCK-1:0] grp_a;
    logic [BLOCK-1:0] grp_b;
    logic [BLOCK-1:0] grp_sum;
    logic             ripple_c;
    logic             grp_prop;
    logic             grp_cout;
    logic             last_grp;
    logic [31:0]      grp_off;
    logic [WIDTH-1:0] grp_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            carry_q <= carry_n;
            idx_q   <= idx_n;
            s_q     <= s_n;
            cout_q  <= cout_n;
            cnt_q   <= cnt_n;
            done_q  <= done_n;
        end
    end

    // Operand registers shift right one group per cycle, so the active group is always the low BLOCK bits.
    always_comb begin
        grp_a    = a_q[BLOCK-1:0];
        grp_b    = b_q[BLOCK-1:0];
        grp_sum  = '0;
        ripple_c = carry_q;
        for (int i = 0; i < BLOCK; i++) begin
            grp_sum[i] = grp_a[i] ^ grp_b[i] ^ ripple_c;
            ripple_c   = (grp_a[i] & grp_b[i]) | (ripple_c & (grp_a[i] ^ grp_b[i]));
        end
        grp_prop = &(grp_a ^ grp_b);
        // A fully propagating group passes its carry-in straight through, bypassing the ripple chain.
        grp_cout = grp_prop ? carry_q : ripple_c;
        last_grp = (idx_q == IW'(NBLK - 1));
        grp_off  = 32'(idx_q) * 32'(BLOCK);
        grp_mask = WIDTH'({BLOCK{1'b1}}) << grp_off;
    end

    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        carry_n = carry_q;
        idx_n   = idx_q;
        s_n     = s_q;
        cout_n  = cout_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    a_n     = A;
                    b_n     = B;
                    carry_n = cin;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                a_n     = a_q >> BLOCK;
                b_n     = b_q >> BLOCK;
                s_n     = (s_q & ~grp_mask) | (WIDTH'(grp_sum) << grp_off);
                carry_n = grp_cout;
                cnt_n   = cnt_q + CW'(grp_prop);
                idx_n   = idx_q + 1'b1;
                if (last_grp) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cout_n  = grp_cout;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign S          = s_q;
    assign Cout       = cout_q;
    assign bypass_cnt = cnt_q;

endmodule
